alu_operand_stage: RTL and testbench

//  ID/EX pipeline stage sitting directly upstream of the ALU. Takes decoded ops plus

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/operand_fwd_mux.sv | 40 ++++
 rtl/alu_operand_stage.sv | 146 ++++++++++++++
 tb/tb_alu_operand_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the ID/EX operand stage.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;
  localparam int unsigned ALUW = 3;

  localparam logic [ALUW-1:0] ALU_AND = 3'b000;
  localparam logic [ALUW-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUW-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUW-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUW-1:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic [ALUW-1:0] alucontrol;
    logic [REGW-1:0] rd;
    logic            regwrite;
  } op_entry_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand source select: x0 forces zero, optional MEM/WB bypass over regfile data.
// Bypass logic is compiled in only when ALU_OPERAND_FWD_EN is defined.
module operand_fwd_mux #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic [REGW-1:0] rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic            fwd_mem_valid,
  input  logic [REGW-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_valid,
  input  logic [REGW-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic [XLEN-1:0] val_c
);

`ifndef ALU_OPERAND_FWD_EN
  // Bypass inputs exist for a uniform interface but do not affect the operand.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                        fwd_wb_valid, fwd_wb_rd, fwd_wb_data};
`endif

  // Select operand value; the youngest producer (MEM) wins, x0 always reads zero.
  always_comb begin
    val_c = rf_data;
`ifdef ALU_OPERAND_FWD_EN
    if (fwd_mem_valid && (fwd_mem_rd == rs)) begin
      val_c = fwd_mem_data;
    end else if (fwd_wb_valid && (fwd_wb_rd == rs)) begin
      val_c = fwd_wb_data;
    end
`endif
    if (rs == '0) begin
      val_c = '0;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: resolves ALU operands at accept time and holds them in a
// 2-entry skid buffer (head register drives the ALU, skid catches one extra op).
// Optional operand bypass: define ALU_OPERAND_FWD_EN.
module alu_operand_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [REGW-1:0] in_rs1,
  input  logic [REGW-1:0] in_rs2,
  input  logic [XLEN-1:0] in_rd1,
  input  logic [XLEN-1:0] in_rd2,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_alusrc,
  input  logic [ALUW-1:0] in_alucontrol,
  input  logic [REGW-1:0] in_rd,
  input  logic            in_regwrite,
  input  logic            fwd_mem_valid,
  input  logic [REGW-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_valid,
  input  logic [REGW-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] srca,
  output logic [XLEN-1:0] srcb,
  output logic [ALUW-1:0] alucontrol,
  output logic [REGW-1:0] out_rd,
  output logic            out_regwrite
);

  logic [XLEN-1:0] rs1_val_c;
  logic [XLEN-1:0] rs2_val_c;
  op_entry_t       new_entry_c;
  op_entry_t       head_q, head_d;
  op_entry_t       skid_q, skid_d;
  buf_state_t      state_q, state_d;
  logic            out_valid_q;
  logic            in_ready_q;
  logic            acc_c;
  logic            emit_c;

  operand_fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_mux_rs1 (
    .rs            (in_rs1),
    .rf_data       (in_rd1),
    .fwd_mem_valid (fwd_mem_valid),
    .fwd_mem_rd    (fwd_mem_rd),
    .fwd_mem_data  (fwd_mem_data),
    .fwd_wb_valid  (fwd_wb_valid),
    .fwd_wb_rd     (fwd_wb_rd),
    .fwd_wb_data   (fwd_wb_data),
    .val_c         (rs1_val_c)
  );

  operand_fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_mux_rs2 (
    .rs            (in_rs2),
    .rf_data       (in_rd2),
    .fwd_mem_valid (fwd_mem_valid),
    .fwd_mem_rd    (fwd_mem_rd),
    .fwd_mem_data  (fwd_mem_data),
    .fwd_wb_valid  (fwd_wb_valid),
    .fwd_wb_rd     (fwd_wb_rd),
    .fwd_wb_data   (fwd_wb_data),
    .val_c         (rs2_val_c)
  );

  assign acc_c  = in_valid & in_ready_q;
  assign emit_c = out_valid_q & out_ready;

  // Build the entry captured on accept; immediate overrides rs2 for srcb.
  always_comb begin
    new_entry_c            = '0;
    new_entry_c.srca       = rs1_val_c;
    new_entry_c.srcb       = in_alusrc ? in_imm : rs2_val_c;
    new_entry_c.alucontrol = in_alucontrol;
    new_entry_c.rd         = in_rd;
    new_entry_c.regwrite   = in_regwrite;
  end

  // Buffer occupancy FSM and entry movement; flush overrides everything.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (acc_c) begin
          state_d = ONE;
          head_d  = new_entry_c;
        end
      end
      ONE: begin
        if (acc_c && emit_c) begin
          head_d = new_entry_c;
        end else if (acc_c) begin
          state_d = TWO;
          skid_d  = new_entry_c;
        end else if (emit_c) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (emit_c) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  // State, entries and handshake flags; handshakes are precomputed from next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != TWO);
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign srca         = head_q.srca;
  assign srcb         = head_q.srcb;
  assign alucontrol   = head_q.alucontrol;
  assign out_rd       = head_q.rd;
  assign out_regwrite = head_q.regwrite;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: driver queues expected entries on accept,
// monitor pops and compares on every emit.
module tb_alu_operand_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_rd1, in_rd2, in_imm;
  logic        in_alusrc;
  logic [2:0]  in_alucontrol;
  logic        in_regwrite;
  logic        fwd_mem_valid, fwd_wb_valid;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] srca, srcb;
  logic [2:0]  alucontrol;
  logic [4:0]  out_rd;
  logic        out_regwrite;

  int tests = 0;
  int fails = 0;
  int stalls = 0;
  op_entry_t exp_q[$];

  alu_operand_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd1(in_rd1), .in_rd2(in_rd2),
    .in_imm(in_imm), .in_alusrc(in_alusrc), .in_alucontrol(in_alucontrol),
    .in_rd(in_rd), .in_regwrite(in_regwrite),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .srca(srca), .srcb(srcb), .alucontrol(alucontrol),
    .out_rd(out_rd), .out_regwrite(out_regwrite)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one op (called at posedge+1) and hold it until accepted.
  task automatic send(input logic [4:0] rs1, input logic [31:0] rd1,
                      input logic [4:0] rs2, input logic [31:0] rd2,
                      input logic [31:0] imm, input logic alusrc, input logic [2:0] op,
                      input logic [4:0] rd, input logic rw,
                      input logic [31:0] ea, input logic [31:0] eb);
    int n;
    op_entry_t e;
    in_rs1 = rs1; in_rd1 = rd1; in_rs2 = rs2; in_rd2 = rd2; in_imm = imm;
    in_alusrc = alusrc; in_alucontrol = op; in_rd = rd; in_regwrite = rw;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end else begin
      e.srca = ea; e.srcb = eb; e.alucontrol = op; e.rd = rd; e.regwrite = rw;
      exp_q.push_back(e);
      stalls += n;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for the scoreboard to empty (bounded), ending at posedge+1.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 80'(exp_q.size()), 80'd0);
  endtask

  // Monitor: compare every emitted op against the oldest expected entry.
  initial begin
    op_entry_t e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_emit: got srca=%0h srcb=%0h expected no output", srca, srcb);
        end else begin
          e = exp_q.pop_front();
          check("emit", 80'({srca, srcb, alucontrol, out_rd, out_regwrite}), 80'(e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e4a, e4b, e4c, e4d;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd1 = '0; in_rd2 = '0; in_imm = '0;
    in_alusrc = 1'b0; in_alucontrol = '0; in_regwrite = 1'b0;
    fwd_mem_valid = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
    fwd_wb_valid = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;

    // Reset state
    #2;
    check("rst_out_valid", 80'(out_valid), 80'd0);
    check("rst_in_ready", 80'(in_ready), 80'd0);
    check("rst_payload", 80'({srca, srcb, alucontrol, out_rd, out_regwrite}), 80'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", 80'(in_ready), 80'd1);
    check("rel_out_valid", 80'(out_valid), 80'd0);

    // Streaming ADD at full throughput
    out_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      send(5'd3, 32'd5 + 32'(i), 5'd4, 32'd7 + 32'(2 * i), 32'h0, 1'b0, ALU_ADD, 5'd10, 1'b1,
           32'd5 + 32'(i), 32'd7 + 32'(2 * i));
      if (i == 0) check("latency_out_valid", 80'(out_valid), 80'd1);
    end
    check("throughput_stalls", 80'(stalls), 80'd0);
    drain("drain_stream");

    // Backpressure: two fit, third stalls, order preserved
    out_ready = 1'b0;
    send(5'd1, 32'h100, 5'd2, 32'h200, 32'h0, 1'b0, ALU_SUB, 5'd9, 1'b1, 32'h100, 32'h200);
    send(5'd1, 32'h101, 5'd2, 32'h201, 32'h0, 1'b0, ALU_AND, 5'd8, 1'b0, 32'h101, 32'h201);
    in_valid = 1'b1;
    @(negedge clk);
    check("full_in_ready", 80'(in_ready), 80'd0);
    check("full_head_srca", 80'(srca), 80'h100);
    @(negedge clk);
    check("stable_head", 80'({srca, srcb, out_rd}), 80'({32'h100, 32'h200, 5'd9}));
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(5'd1, 32'h102, 5'd2, 32'h202, 32'h0, 1'b0, ALU_OR, 5'd7, 1'b1, 32'h102, 32'h202);
    drain("drain_backpressure");

    // Bypass priority and x0
`ifdef ALU_OPERAND_FWD_EN
    e4a = 32'hAA; e4b = 32'hBB; e4c = 32'hAA; e4d = 32'hAA;
`else
    e4a = 32'h11; e4b = 32'h22; e4c = 32'h44; e4d = 32'h11;
`endif
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'hAA;
    fwd_wb_valid = 1'b1;  fwd_wb_rd = 5'd5;  fwd_wb_data = 32'hBB;
    send(5'd5, 32'h11, 5'd12, 32'h33, 32'h0, 1'b0, ALU_ADD, 5'd1, 1'b1, e4a, 32'h33);
    fwd_wb_rd = 5'd6;
    send(5'd6, 32'h22, 5'd5, 32'h44, 32'h0, 1'b0, ALU_SLT, 5'd2, 1'b1, e4b, e4c);
    fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
    send(5'd0, 32'h55, 5'd0, 32'h66, 32'h0, 1'b0, ALU_ADD, 5'd3, 1'b1, 32'h0, 32'h0);

    // Immediate select ignores rs2 and bypass
    fwd_mem_rd = 5'd5;
    send(5'd5, 32'h11, 5'd5, 32'h77, 32'hFFFFFFFC, 1'b1, ALU_ADD, 5'd4, 1'b1, e4d, 32'hFFFFFFFC);
    fwd_mem_valid = 1'b0; fwd_wb_valid = 1'b0;
    drain("drain_fwd_imm");

    // Flush in TWO with in_valid high
    out_ready = 1'b0;
    send(5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 1'b0, ALU_ADD, 5'd5, 1'b1, 32'h1, 32'h2);
    send(5'd1, 32'h3, 5'd2, 32'h4, 32'h0, 1'b0, ALU_ADD, 5'd6, 1'b1, 32'h3, 32'h4);
    in_rd1 = 32'hDEAD; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_two_out_valid", 80'(out_valid), 80'd0);
    check("flush_two_in_ready", 80'(in_ready), 80'd1);
    exp_q.delete();

    // Flush in ONE drops the same-cycle accept
    send(5'd1, 32'h5, 5'd2, 32'h6, 32'h0, 1'b0, ALU_ADD, 5'd7, 1'b1, 32'h5, 32'h6);
    in_rd1 = 32'hBEEF; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_one_out_valid", 80'(out_valid), 80'd0);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("flush_no_emit", 80'(out_valid), 80'd0);
    send(5'd1, 32'h9, 5'd2, 32'hA, 32'h0, 1'b0, ALU_OR, 5'd11, 1'b1, 32'h9, 32'hA);
    drain("drain_after_flush");

    // Async reset mid-TWO
    out_ready = 1'b0;
    send(5'd1, 32'h7, 5'd2, 32'h8, 32'h0, 1'b0, ALU_ADD, 5'd5, 1'b1, 32'h7, 32'h8);
    send(5'd1, 32'h9, 5'd2, 32'hA, 32'h0, 1'b0, ALU_ADD, 5'd6, 1'b1, 32'h9, 32'hA);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 80'(out_valid), 80'd0);
    check("arst_in_ready", 80'(in_ready), 80'd0);
    check("arst_srca", 80'(srca), 80'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("arst_rel_before_edge", 80'(in_ready), 80'd0);
    @(posedge clk); #1;
    check("arst_rel_in_ready", 80'(in_ready), 80'd1);
    check("arst_rel_out_valid", 80'(out_valid), 80'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
